unlock_attempt_scheduler: RTL
=============================

UNLOCK_ATTEMPT_SCHEDULER -- requirements
Module: unlock_attempt_scheduler

Interface
REQ-001 SHALL have parameter N, default 4, nibble width forwarded to the unlocking datapath.
REQ-002 SHALL have parameter WORDS, default 4, nibbles per password attempt.
REQ-003 SHALL have parameter MAX_FAIL, default 3, consecutive failures that trigger lockout.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, lockout duration in clocks.
REQ-005 SHALL have parameter RES_TIMEOUT, default 8, maximum clocks to wait for a result.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have ports a_data, a_valid and a_ready: input N, input 1 and output 1, requester A nibble stream.
REQ-009 SHALL have ports b_data, b_valid and b_ready: input N, input 1 and output 1, requester B nibble stream.
REQ-010 SHALL have ports p_data, p_valid and p_ready: output N, output 1 and input 1, the unlocking datapath parallel input.
REQ-011 SHALL have ports unlock and pwd_incorrect, both input 1, result pulses from the datapath.
REQ-012 SHALL have ports res_valid, res_port and res_ok, all output 1: result strobe, requester index (0=A, 1=B) and pass flag.
REQ-013 SHALL have ports locked, output 1, and fail_cnt, output $clog2(MAX_FAIL+1) bits, lockout flag and consecutive-failure count.

Function
REQ-014 SHALL implement the states IDLE, XFER, WAIT_RES, COOL and LOCKOUT.
REQ-015 IDLE: SHALL grant the valid requester; if both are valid, SHALL grant the one not granted last (round-robin; A wins first after reset); SHALL enter XFER on the next clock.
REQ-016 XFER: p_data/p_valid SHALL mux the granted requester combinationally, and granted ready = p_ready; the other ready SHALL be 0.
REQ-017 XFER SHALL count handshakes (p_valid&&p_ready) and enter WAIT_RES on the handshake of nibble WORDS; the grant SHALL be held for the entire attempt.
REQ-018 WAIT_RES: all readies and p_valid SHALL be 0; unlock SHALL give success and pwd_incorrect SHALL give failure; if both are high in the same cycle, it SHALL give failure.
REQ-019 On result, SHALL pulse res_valid for exactly one clock the cycle after detection, with res_port=grant and res_ok=success.
REQ-020 unlock or pwd_incorrect arriving during XFER (early reject) SHALL abort the attempt as failure, apply REQ-019, and let the requester's remaining nibbles stall until COOL exits.
REQ-021 Success SHALL clear fail_cnt; failure SHALL increment fail_cnt, saturating at MAX_FAIL.
REQ-022 After any result, SHALL enter COOL for 2 clocks (covering the datapath self-reset) with all readies 0, then SHALL go to IDLE, or to LOCKOUT if fail_cnt==MAX_FAIL.
REQ-023 LOCKOUT: locked=1 and all readies 0 for exactly LOCK_CYCLES clocks; then SHALL clear fail_cnt and locked and return to IDLE.
REQ-024 Requester valid deasserting mid-attempt SHALL NOT release the grant; the attempt SHALL simply stall.
REQ-025 Result pulses in IDLE, COOL or LOCKOUT SHALL be ignored.

Reset
REQ-026 With rst_n=0 at a clock edge, SHALL enter IDLE with grant pointer at A and counters cleared.
REQ-027 Outputs during reset SHALL be: a_ready=b_ready=p_valid=res_valid=res_ok=res_port=locked=0, fail_cnt=0, p_data=0.
REQ-028 Reset mid-attempt or mid-lockout SHALL discard the attempt without a res_valid pulse.

Configuration
REQ-029 With UNLOCK_SCHED_TIMEOUT_EN defined, WAIT_RES SHALL count clocks and, after RES_TIMEOUT clocks with no result, SHALL treat the attempt as failure (REQ-019, REQ-021, REQ-022).
REQ-030 Without UNLOCK_SCHED_TIMEOUT_EN, WAIT_RES SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-031 A sends 4 nibbles with p_ready=1 and unlock pulses 2 clocks later -> one res_valid pulse with res_port=0, res_ok=1, fail_cnt=0.
REQ-032 A and B are both valid from reset -> A is served first, then B; a second contention -> A is served again only after B.
REQ-033 Three consecutive pwd_incorrect results -> fail_cnt 1,2,3, locked=1 for exactly 16 clocks with readies 0, then fail_cnt=0.
REQ-034 pwd_incorrect arrives after nibble 2 of 4 -> abort, res_ok=0, COOL 2 clocks, then IDLE.
REQ-035 With UNLOCK_SCHED_TIMEOUT_EN and no result for 8 clocks -> res_ok=0, fail_cnt+1; without the macro -> remains in WAIT_RES.
REQ-036 rst_n=0 during LOCKOUT -> next clock locked=0, fail_cnt=0, and no res_valid pulse.

Source files
------------

// File: rtl/unlock_attempt_scheduler.sv
// ---------------------------------------------------------------------------
// unlock_attempt_scheduler
//
// Arbitrates password-attempt nibble streams from two requesters (A and B)
// onto the parallel input of a single unlocking datapath. It also collects
// the datapath's pass/fail pulses, reports one result strobe per attempt,
// tracks consecutive failures and enforces a lockout period after too many
// failures in a row.
//
// Optional feature macro: UNLOCK_SCHED_TIMEOUT_EN
//   When defined, an attempt that sees no datapath result within
//   RES_TIMEOUT clocks of its last nibble is closed as a failure. When it is
//   not defined, the scheduler waits for a result indefinitely and carries no
//   timeout counter.
//
// Parameters
//   N            nibble width forwarded to the datapath
//   WORDS        nibbles per password attempt
//   MAX_FAIL     consecutive failures that trigger a lockout
//   LOCK_CYCLES  lockout duration in clocks
//   RES_TIMEOUT  clocks to wait for a result (timeout build only)
//
// Ports
//   clk            single clock, all logic on its rising edge
//   rst_n          synchronous active-low reset
//   a_data/a_valid/a_ready   requester A nibble stream (ready is an output)
//   b_data/b_valid/b_ready   requester B nibble stream (ready is an output)
//   p_data/p_valid/p_ready   datapath parallel input (ready is an input)
//   unlock         datapath pulse: password accepted
//   pwd_incorrect  datapath pulse: password rejected
//   res_valid      one-clock result strobe
//   res_port       requester that owned the attempt (0=A, 1=B)
//   res_ok         attempt passed
//   locked         lockout in progress
//   fail_cnt       consecutive-failure count, saturating at MAX_FAIL
// ---------------------------------------------------------------------------
module unlock_attempt_scheduler #(
    parameter int N           = 4,
    parameter int WORDS       = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int RES_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N-1:0]                  a_data,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [N-1:0]                  b_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    output logic [N-1:0]                  p_data,
    output logic                          p_valid,
    input  logic                          p_ready,
    input  logic                          unlock,
    input  logic                          pwd_incorrect,
    output logic                          res_valid,
    output logic                          res_port,
    output logic                          res_ok,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int WW = $clog2(WORDS + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        WAIT_RES,
        COOL,
        LOCKOUT
    } state_t;

    state_t         state;
    state_t         state_next;

    // Current owner of the datapath (0=A, 1=B) and the requester that wins
    // the next tie. After reset A wins the first tie.
    logic           grant;
    logic           prefer_b;
    logic           take_grant;
    logic           grant_next;

    logic [WW-1:0]  word_cnt;
    logic           cool_second;
    logic [LW-1:0]  lock_cnt;

    logic           handshake;
    logic           res_fire;
    logic           res_pass;

`ifdef UNLOCK_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(RES_TIMEOUT + 1);
    logic [TW-1:0]  wait_cnt;
`endif

    assign locked = (state == LOCKOUT);

    // Next-state and datapath steering. Only XFER ever opens a ready or
    // drives p_valid, so every other state keeps both requesters stalled.
    // A result seen during XFER is an early reject and always counts as a
    // failure, whatever the pulse was. In WAIT_RES a simultaneous unlock
    // and pwd_incorrect is also treated as a failure.
    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        p_valid    = 1'b0;
        p_data     = '0;
        take_grant = 1'b0;
        grant_next = grant;
        handshake  = 1'b0;
        res_fire   = 1'b0;
        res_pass   = 1'b0;

        case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
                    take_grant = 1'b1;
                    grant_next = (a_valid && b_valid) ? prefer_b : b_valid;
                    state_next = XFER;
                end
            end

            XFER: begin
                p_data    = grant ? b_data  : a_data;
                p_valid   = grant ? b_valid : a_valid;
                a_ready   = !grant && p_ready;
                b_ready   = grant && p_ready;
                handshake = p_valid && p_ready;
                if (unlock || pwd_incorrect) begin
                    res_fire   = 1'b1;
                    state_next = COOL;
                end else if (handshake && (word_cnt == WW'(WORDS - 1))) begin
                    state_next = WAIT_RES;
                end
            end

            WAIT_RES: begin
                if (unlock || pwd_incorrect) begin
                    res_fire   = 1'b1;
                    res_pass   = unlock && !pwd_incorrect;
                    state_next = COOL;
                end
`ifdef UNLOCK_SCHED_TIMEOUT_EN
                else if (wait_cnt == TW'(RES_TIMEOUT - 1)) begin
                    res_fire   = 1'b1;
                    state_next = COOL;
                end
`endif
            end

            COOL: begin
                if (cool_second) begin
                    state_next = (fail_cnt == FW'(MAX_FAIL)) ? LOCKOUT : IDLE;
                end
            end

            LOCKOUT: begin
                if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the grant bookkeeping. The tie-break pointer
    // flips to the other requester on every grant, so under continuous
    // contention A and B alternate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 1'b0;
            prefer_b <= 1'b0;
        end else begin
            state <= state_next;
            if (take_grant) begin
                grant    <= grant_next;
                prefer_b <= !grant_next;
            end
        end
    end

    // Phase counters. The nibble counter is cleared whenever the next state
    // is not XFER, so each attempt starts from zero. The cool flag marks
    // the second COOL clock, and the lock counter runs only while locked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt    <= '0;
            cool_second <= 1'b0;
            lock_cnt    <= '0;
        end else begin
            if (state_next != XFER) begin
                word_cnt <= '0;
            end else if (handshake) begin
                word_cnt <= word_cnt + WW'(1);
            end

            cool_second <= (state == COOL) && !cool_second;

            if (state == LOCKOUT) begin
                lock_cnt <= lock_cnt + LW'(1);
            end else begin
                lock_cnt <= '0;
            end
        end
    end

`ifdef UNLOCK_SCHED_TIMEOUT_EN
    // Clocks spent in WAIT_RES for the current attempt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT_RES) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    // Result reporting and the consecutive-failure count. The strobe is
    // registered, so it appears the clock after the result is detected,
    // and fail_cnt already shows the updated count in that same clock.
    // The count is cleared again on the last lockout clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_port  <= 1'b0;
            res_ok    <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            res_valid <= res_fire;
            if (res_fire) begin
                res_port <= grant;
                res_ok   <= res_pass;
                if (res_pass) begin
                    fail_cnt <= '0;
                end else if (fail_cnt != FW'(MAX_FAIL)) begin
                    fail_cnt <= fail_cnt + FW'(1);
                end
            end else if ((state == LOCKOUT) && (state_next == IDLE)) begin
                fail_cnt <= '0;
            end
        end
    end

endmodule
